// File: rtl/stack_prog_loader.sv
// Program-memory loader for stackCPU: assembles a byte stream into 16-bit words and holds the CPU
// in reset until a well-formed program is loaded. Optional checksum byte: LOADER_CHECKSUM_EN.
module stack_prog_loader #(
  parameter int unsigned INSTR_WIDTH    = 16,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned PGRM_MEM_DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [7:0]             load_byte,
  input  logic                   load_last,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic                   cpu_hold,
  output logic [PC_WIDTH:0]      load_count,
  output logic                   load_error
);

  localparam int unsigned AddrW = (PGRM_MEM_DEPTH > 1) ? $clog2(PGRM_MEM_DEPTH) : 1;
  localparam logic [PC_WIDTH:0] DepthCnt = (PC_WIDTH + 1)'(PGRM_MEM_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoadHi,
    StLoadLo,
    StRun,
    StErr
`ifdef LOADER_CHECKSUM_EN
    , StChk
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH:0]      count_q, count_d;
  logic [7:0]             hi_q, hi_d;
  logic                   mem_we;
  logic                   accept;
  logic [INSTR_WIDTH-1:0] mem [PGRM_MEM_DEPTH];

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign accept = load_valid && load_ready;

  always_comb begin
    load_ready = 1'b0;
    unique case (state_q)
      StLoadHi, StLoadLo: load_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StChk:              load_ready = 1'b1;
`endif
      default:            load_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    mem_we  = 1'b0;
    // load_start wins over any byte accepted on the same edge, in every state
    if (load_start) begin
      state_d = StLoadHi;
      count_d = '0;
    end else begin
      unique case (state_q)
        StLoadHi: begin
          if (accept) begin
            if (count_q == DepthCnt || load_last) begin
              state_d = StErr;
            end else begin
              hi_d    = load_byte;
              state_d = StLoadLo;
            end
          end
        end
        StLoadLo: begin
          if (accept) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            state_d = load_last ? StChk : StLoadHi;
`else
            state_d = load_last ? StRun : StLoadHi;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: begin
          if (accept) state_d = (load_byte == csum_q) ? StRun : StErr;
        end
`endif
        StIdle, StRun, StErr: state_d = state_q;
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (load_start) begin
      csum_d = '0;
    end else if (accept && (state_q == StLoadHi || state_q == StLoadLo)) begin
      csum_d = csum_q ^ load_byte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
    end
  end

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[AddrW-1:0]] <= {hi_q, load_byte};
  end

  assign cpu_hold    = (state_q != StRun);
  assign load_error  = (state_q == StErr);
  assign load_count  = count_q;
  assign instr_valid = (state_q == StRun) && ({1'b0, pc} < count_q);
  assign instruction = instr_valid ? mem[pc[AddrW-1:0]] : '1;

endmodule
